// File: rtl/nanorv32_periph_pkg.sv
// nanorv32 peripheral-bus shared definitions.
// Holds the timer register offsets (word index = addr[4:2]), the CTRL bit
// indices, the responder FSM state encoding and a byte-lane merge helper.
package nanorv32_periph_pkg;

  // Register offsets expressed as word indices (byte offset / 4).
  localparam logic [2:0] TIMER_CTRL_OFF     = 3'd0;
  localparam logic [2:0] TIMER_PRESCALE_OFF = 3'd1;
  localparam logic [2:0] TIMER_COUNT_OFF    = 3'd2;
  localparam logic [2:0] TIMER_COMPARE_OFF  = 3'd3;
  localparam logic [2:0] TIMER_STATUS_OFF   = 3'd4;

  // CTRL bit positions.
  localparam int CTRL_EN_BIT         = 0;
  localparam int CTRL_AUTORELOAD_BIT = 1;
  localparam int CTRL_IRQEN_BIT      = 2;

  // Handshake FSM encoding.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // Replace the byte lanes selected by bytesel with the matching bytes of din.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] din,
                                              input logic [3:0]  bytesel);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (bytesel[i]) res[8*i +: 8] = din[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/nanorv32_periph_timer_if.sv
// nanorv32 peripheral bus bundle.
// master: periph_addr, periph_bytesel (nonzero = write), periph_din, periph_en.
// slave : periph_dout (registered read data), periph_ready_nxt (accept strobe).
interface nanorv32_periph_timer_if #(
  parameter int ADDR_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0] periph_addr;
  logic [3:0]            periph_bytesel;
  logic [31:0]           periph_din;
  logic                  periph_en;
  logic [31:0]           periph_dout;
  logic                  periph_ready_nxt;

  modport master (
    output periph_addr, periph_bytesel, periph_din, periph_en,
    input  periph_dout, periph_ready_nxt
  );

  modport slave (
    input  periph_addr, periph_bytesel, periph_din, periph_en,
    output periph_dout, periph_ready_nxt
  );
endinterface

// File: rtl/nanorv32_periph_slave_if.sv
// nanorv32 peripheral-bus responder handshake.
// Inserts WAIT_STATES cycles before accepting a request; a request dropped
// while waiting is abandoned. Emits one-cycle wr_en/rd_en strobes on accept.
// Ports: clk, rst_n, en, addr, bytesel in; ready_nxt, wr_en, rd_en, offset out.
module nanorv32_periph_slave_if
  import nanorv32_periph_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [3:0]            bytesel,
  output logic                  ready_nxt,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [2:0]            offset
);

  localparam logic [3:0] WCNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
  localparam bit         NO_WAIT   = (WAIT_STATES == 0);

  logic [0:0] state;
  logic [3:0] wcnt;

  // Only addr[4:2] selects a register; the remaining bits are don't-care.
  logic unused_addr;
  assign unused_addr = ^{addr[ADDR_WIDTH-1:5], addr[1:0]};

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves it unassigned (which would infer a latch).
  always_comb begin
    ready_nxt = 1'b0;
    case (state)
      ST_IDLE: ready_nxt = en && NO_WAIT;
      ST_WAIT: ready_nxt = en && (wcnt == 4'd0);
      default: ready_nxt = 1'b0;
    endcase
  end

  assign wr_en  = ready_nxt && (bytesel != 4'd0);
  assign rd_en  = ready_nxt && (bytesel == 4'd0);
  assign offset = addr[4:2];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      wcnt  <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en && !NO_WAIT) begin
            state <= ST_WAIT;
            wcnt  <= WCNT_INIT;
          end
        end
        ST_WAIT: begin
          if (!en)                state <= ST_IDLE;   // requester gave up
          else if (wcnt != 4'd0)  wcnt  <= wcnt - 4'd1;
          else                    state <= ST_IDLE;   // accepted this edge
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/nanorv32_periph_timer.sv
// nanorv32 memory-mapped timer on the peripheral bus (0xF000_0000 space).
// Registers: CTRL(EN,AUTORELOAD,IRQEN), PRESCALE, COUNT, COMPARE, STATUS(MATCH W1C).
// Ports: clk, rst_n (async, active-low), bus (slave modport), timer_irq (level).
// Optional: define NANORV32_PERIPH_TIMER_PRESCALER_EN for the prescaler;
// otherwise the counter ticks every cycle while enabled and PRESCALE reads 0.
module nanorv32_periph_timer
  import nanorv32_periph_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  nanorv32_periph_timer_if.slave       bus,
  output logic                         timer_irq
);

  logic        ready_nxt, wr_en, rd_en;
  logic [2:0]  offset;

  nanorv32_periph_slave_if #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .WAIT_STATES(WAIT_STATES)
  ) u_slave (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (bus.periph_en),
    .addr     (bus.periph_addr),
    .bytesel  (bus.periph_bytesel),
    .ready_nxt(ready_nxt),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .offset   (offset)
  );

  assign bus.periph_ready_nxt = ready_nxt;

  logic [2:0]  ctrl;
  logic [31:0] count, compare, count_nxt, rdata, dout;
  logic        match, tick, hit, w1c;

  assign hit = (count == compare);
  assign w1c = wr_en && (offset == TIMER_STATUS_OFF) &&
               bus.periph_bytesel[0] && bus.periph_din[0];

`ifdef NANORV32_PERIPH_TIMER_PRESCALER_EN
  logic [7:0] prescale, pscnt;
  assign tick = ctrl[CTRL_EN_BIT] && (pscnt == prescale);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale <= 8'd0;
      pscnt    <= 8'd0;
    end else if (wr_en && offset == TIMER_PRESCALE_OFF) begin
      if (bus.periph_bytesel[0]) prescale <= bus.periph_din[7:0];
      pscnt <= 8'd0;                      // restart the period on any write
    end else if (ctrl[CTRL_EN_BIT]) begin
      pscnt <= tick ? 8'd0 : pscnt + 8'd1;
    end
  end
`else
  assign tick = ctrl[CTRL_EN_BIT];
`endif

  // Timer update first, then the bus write overrides only the lanes it touches.
  always_comb begin
    count_nxt = count;
    if (tick) count_nxt = (hit && ctrl[CTRL_AUTORELOAD_BIT]) ? 32'd0 : count + 32'd1;
    if (wr_en && offset == TIMER_COUNT_OFF)
      count_nxt = merge_bytes(count_nxt, bus.periph_din, bus.periph_bytesel);
  end

  always_comb begin
    rdata = 32'd0;
    case (offset)
      TIMER_CTRL_OFF:     rdata = {29'd0, ctrl};
`ifdef NANORV32_PERIPH_TIMER_PRESCALER_EN
      TIMER_PRESCALE_OFF: rdata = {24'd0, prescale};
`endif
      TIMER_COUNT_OFF:    rdata = count;
      TIMER_COMPARE_OFF:  rdata = compare;
      TIMER_STATUS_OFF:   rdata = {31'd0, match};
      default:            rdata = 32'd0;
    endcase
  end

  // NOTE: every register here, read-data included, is cleared by the
  // asynchronous reset so an aborted access leaves no stale state behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl    <= 3'd0;
      count   <= 32'd0;
      compare <= 32'd0;
      match   <= 1'b0;
      dout    <= 32'd0;
    end else begin
      count <= count_nxt;
      match <= (tick && hit) || (match && !w1c);   // a new match beats the clear
      if (wr_en && offset == TIMER_CTRL_OFF && bus.periph_bytesel[0])
        ctrl <= bus.periph_din[2:0];
      if (wr_en && offset == TIMER_COMPARE_OFF)
        compare <= merge_bytes(compare, bus.periph_din, bus.periph_bytesel);
      if (rd_en) dout <= rdata;
    end
  end

  assign bus.periph_dout = dout;
  assign timer_irq       = match && ctrl[CTRL_IRQEN_BIT];

endmodule

// File: tb/tb_nanorv32_periph_timer.sv
// Directed bench for nanorv32_periph_timer: one instance with no wait states
// and one with three, sharing clock and reset.
module tb_nanorv32_periph_timer;
  import nanorv32_periph_pkg::*;

  localparam logic [11:0] A_CTRL     = {7'd0, TIMER_CTRL_OFF,     2'b00};
  localparam logic [11:0] A_PRESCALE = {7'd0, TIMER_PRESCALE_OFF, 2'b00};
  localparam logic [11:0] A_COUNT    = {7'd0, TIMER_COUNT_OFF,    2'b00};
  localparam logic [11:0] A_COMPARE  = {7'd0, TIMER_COMPARE_OFF,  2'b00};
  localparam logic [11:0] A_STATUS   = {7'd0, TIMER_STATUS_OFF,   2'b00};
  localparam logic [11:0] A_HOLE     = 12'h018;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic irq0, irq3;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  nanorv32_periph_timer_if #(.ADDR_WIDTH(12)) b0 ();
  nanorv32_periph_timer_if #(.ADDR_WIDTH(12)) b3 ();

  nanorv32_periph_timer #(.ADDR_WIDTH(12), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0), .timer_irq(irq0));
  nanorv32_periph_timer #(.ADDR_WIDTH(12), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(b3), .timer_irq(irq3));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Drive a request at a falling edge, wait (bounded) for ready_nxt, let the
  // accepting rising edge pass, drop en and return dout. lat counts whole
  // cycles between raising en and seeing ready_nxt.
  task automatic access(input bit s3, input logic [11:0] addr, input logic [3:0] bsel,
                        input logic [31:0] din, output logic [31:0] rdata, output int lat);
    @(negedge clk);
    if (s3) begin
      b3.periph_addr = addr; b3.periph_bytesel = bsel; b3.periph_din = din; b3.periph_en = 1'b1;
    end else begin
      b0.periph_addr = addr; b0.periph_bytesel = bsel; b0.periph_din = din; b0.periph_en = 1'b1;
    end
    #1;
    lat = 0;
    while (!(s3 ? b3.periph_ready_nxt : b0.periph_ready_nxt) && lat < 20) begin
      @(negedge clk); #1;
      lat++;
    end
    @(posedge clk); #1;
    if (s3) begin b3.periph_en = 1'b0; rdata = b3.periph_dout; end
    else    begin b0.periph_en = 1'b0; rdata = b0.periph_dout; end
  endtask

  task automatic wr(input bit s3, input logic [11:0] addr, input logic [3:0] bsel,
                    input logic [31:0] din);
    logic [31:0] r;
    int l;
    access(s3, addr, bsel, din, r, l);
    check("wr_latency", 32'(l), s3 ? 32'd3 : 32'd0);
  endtask

  task automatic rd(input bit s3, input logic [11:0] addr, output logic [31:0] r);
    int l;
    access(s3, addr, 4'h0, 32'd0, r, l);
    check("rd_latency", 32'(l), s3 ? 32'd3 : 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    int          l;
    bit          seen;

    b0.periph_addr = '0; b0.periph_bytesel = '0; b0.periph_din = '0; b0.periph_en = 1'b0;
    b3.periph_addr = '0; b3.periph_bytesel = '0; b3.periph_din = '0; b3.periph_en = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout0",  b0.periph_dout, 32'd0);
    check("rst_ready0", {31'd0, b0.periph_ready_nxt}, 32'd0);
    check("rst_irq0",   {31'd0, irq0}, 32'd0);
    check("rst_ready3", {31'd0, b3.periph_ready_nxt}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Zero wait states: write then read COMPARE.
    wr(1'b0, A_COMPARE, 4'hF, 32'h0000_0010);
    access(1'b0, A_COMPARE, 4'h0, 32'd0, r, l);
    check("ws0_ready_same_cycle", 32'(l), 32'd0);
    check("ws0_compare", r, 32'h0000_0010);
    rd(1'b0, A_HOLE, r);
    check("hole_reads_zero", r, 32'd0);

    // Three wait states.
    rd(1'b1, A_CTRL, r);
    check("ws3_ctrl_rst", r, 32'd0);
    wr(1'b1, A_CTRL, 4'hF, 32'h0000_0004);
    rd(1'b1, A_CTRL, r);
    check("ws3_ctrl", r, 32'h0000_0004);

    // Abort a write to CTRL after one cycle.
    @(negedge clk);
    b3.periph_addr = A_CTRL; b3.periph_bytesel = 4'hF; b3.periph_din = 32'h1; b3.periph_en = 1'b1;
    @(negedge clk);
    b3.periph_en = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1 seen |= b3.periph_ready_nxt;
      @(negedge clk);
    end
    check("abort_no_ready", {31'd0, seen}, 32'd0);
    check("abort_dout_held", b3.periph_dout, 32'h0000_0004);
    rd(1'b1, A_CTRL, r);   // exact latency 3 shows the FSM went back to IDLE
    check("abort_no_write", r, 32'h0000_0004);

    // Compare match with auto-reload and interrupt.
    wr(1'b0, A_COMPARE, 4'hF, 32'd5);
    wr(1'b0, A_PRESCALE, 4'hF, 32'd0);
    wr(1'b0, A_CTRL, 4'hF, 32'h7);         // enabled from this edge on
    repeat (5) @(posedge clk);
    #1 check("irq_before_6th_tick", {31'd0, irq0}, 32'd0);
    @(posedge clk);
    #1 check("irq_on_6th_tick", {31'd0, irq0}, 32'd1);
    rd(1'b0, A_COUNT, r);
    check("count_reloaded", r, 32'd0);
    rd(1'b0, A_STATUS, r);
    check("status_match", r, 32'd1);
    wr(1'b0, A_STATUS, 4'h1, 32'h1);
    check("irq_cleared", {31'd0, irq0}, 32'd0);
    wr(1'b0, A_CTRL, 4'hF, 32'h0);
    rd(1'b0, A_COUNT, r);
    check("count_frozen", r, 32'd4);

    // Wrap without auto-reload.
    wr(1'b0, A_COMPARE, 4'hF, 32'h10);
    wr(1'b0, A_COUNT, 4'hF, 32'hFFFF_FFFE);
    wr(1'b0, A_CTRL, 4'hF, 32'h1);
    rd(1'b0, A_COUNT, r);
    check("wrap_0", r, 32'hFFFF_FFFE);
    rd(1'b0, A_COUNT, r);
    check("wrap_1", r, 32'hFFFF_FFFF);
    rd(1'b0, A_COUNT, r);
    check("wrap_2", r, 32'h0);
    rd(1'b0, A_STATUS, r);
    check("wrap_no_match", r, 32'd0);
    wr(1'b0, A_CTRL, 4'hF, 32'h0);

    // Prescaler.
    wr(1'b0, A_COUNT, 4'hF, 32'd0);
    wr(1'b0, A_PRESCALE, 4'hF, 32'd3);
    rd(1'b0, A_PRESCALE, r);
`ifdef NANORV32_PERIPH_TIMER_PRESCALER_EN
    check("prescale_rd", r, 32'd3);
`else
    check("prescale_rd", r, 32'd0);
`endif
    wr(1'b0, A_CTRL, 4'hF, 32'h1);
    repeat (4) @(posedge clk);
    rd(1'b0, A_COUNT, r);
`ifdef NANORV32_PERIPH_TIMER_PRESCALER_EN
    check("prescale_count_a", r, 32'd1);
`else
    check("prescale_count_a", r, 32'd4);
`endif
    repeat (3) @(posedge clk);
    rd(1'b0, A_COUNT, r);
`ifdef NANORV32_PERIPH_TIMER_PRESCALER_EN
    check("prescale_count_b", r, 32'd2);
`else
    check("prescale_count_b", r, 32'd8);
`endif
    wr(1'b0, A_CTRL, 4'hF, 32'h0);

    // Byte-lane write.
    wr(1'b0, A_COMPARE, 4'hF, 32'h1122_3344);
    wr(1'b0, A_COMPARE, 4'h2, 32'h0000_AB00);
    rd(1'b0, A_COMPARE, r);
    check("byte_write", r, 32'h1122_AB44);

    // W1C on the same edge as a new match: match must survive.
    wr(1'b0, A_COMPARE, 4'hF, 32'd3);
    wr(1'b0, A_COUNT, 4'hF, 32'd0);
    wr(1'b0, A_PRESCALE, 4'hF, 32'd0);
    wr(1'b0, A_CTRL, 4'hF, 32'h1);
    repeat (3) @(posedge clk);
    wr(1'b0, A_STATUS, 4'h1, 32'h1);
    rd(1'b0, A_STATUS, r);
    check("set_beats_w1c", r, 32'd1);
    wr(1'b0, A_CTRL, 4'hF, 32'h0);
    wr(1'b0, A_STATUS, 4'h1, 32'h1);
    rd(1'b0, A_STATUS, r);
    check("w1c_clears", r, 32'd0);
    rd(1'b0, A_COMPARE, r);
    check("compare_before_rst", r, 32'd3);

    // Asynchronous reset in the middle of a wait-state write.
    @(negedge clk);
    b3.periph_addr = A_CTRL; b3.periph_bytesel = 4'hF; b3.periph_din = 32'h7; b3.periph_en = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_dout0",  b0.periph_dout, 32'd0);
    check("arst_dout3",  b3.periph_dout, 32'd0);
    check("arst_ready3", {31'd0, b3.periph_ready_nxt}, 32'd0);
    repeat (2) @(posedge clk);
    b3.periph_en = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    rd(1'b1, A_CTRL, r);
    check("arst_ctrl3", r, 32'd0);
    rd(1'b0, A_COMPARE, r);
    check("arst_compare0", r, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global time bound so a stuck handshake cannot hang the run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nanorv32_periph_timer.md
Name: nanorv32_periph_timer

Overview:
- Responder on the nanorv32 peripheral bus, driven by the TCM/peripheral arbiter's periph_* outputs.
- Implements the periph_en / periph_ready_nxt handshake with a configurable number of wait states.
- Hosts a memory-mapped 32-bit timer with compare match, auto-reload and an interrupt output.
- First real peripheral on the 0xF000_0000 space; doubles as the bus-protocol reference responder.

Parameters:
- ADDR_WIDTH, 12, width of periph_addr; only addr[4:2] are decoded.
- WAIT_STATES, 0, extra cycles inserted before periph_ready_nxt; legal range 0..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- periph_addr  in  ADDR_WIDTH  byte address; held stable while periph_en=1 until accept
- periph_bytesel  in  4  byte lanes; nonzero = write, 0 = read
- periph_din  in  32  write data
- periph_en  in  1  request
- periph_dout  out  32  read data, registered; valid the cycle after accept
- periph_ready_nxt  out  1  accept strobe; the requester registers it into ready_r
- timer_irq  out  1  level interrupt

Behaviour:
- Reset values:
  - periph_dout=0, periph_ready_nxt=0, timer_irq=0.
  - All registers 0; FSM in IDLE; prescale counter 0.
- Register map (offset = addr[4:2]*4):
  - 0x00 CTRL: bit0 EN, bit1 AUTORELOAD, bit2 IRQEN; other bits read 0.
  - 0x04 PRESCALE[7:0].
  - 0x08 COUNT.
  - 0x0C COMPARE.
  - 0x10 STATUS: bit0 MATCH, write-1-to-clear.
  - Other offsets read 0; writes to them are ignored; they still complete the handshake.
- Handshake FSM, states IDLE and WAIT:
  - IDLE, periph_en=1, WAIT_STATES=0: periph_ready_nxt=1 combinationally the same cycle; access is performed at that clock edge.
  - IDLE, periph_en=1, WAIT_STATES>0: load wcnt=WAIT_STATES-1 and go to WAIT. periph_ready_nxt=0.
  - WAIT, wcnt≠0: decrement wcnt. If wcnt=0: periph_ready_nxt=1, accept, return to IDLE.
  - periph_en falls while in WAIT: abort. Return to IDLE; no register side effect; dout unchanged.
  - Accept-to-accept latency is WAIT_STATES+1 cycles. Back-to-back requests (en held high after accept) start a new transaction immediately.
- Accept, read: periph_dout <= selected register at the clock edge, so data is valid on the cycle the requester sees ready_r=1. periph_dout holds its value otherwise.
- Accept, write: per-lane update. bytesel[i] writes din[8i+7:8i]. STATUS clears bit0 only if bytesel[0]=1 and din[0]=1.
- Timer:
  - When EN=1, the prescale counter increments each cycle. tick=1 when it equals PRESCALE, then it resets to 0.
  - PRESCALE=0 gives a tick every cycle.
  - On tick with COUNT==COMPARE: set MATCH; COUNT <= AUTORELOAD ? 0 : COUNT+1.
  - On tick with COUNT≠COMPARE: COUNT <= COUNT+1, modulo 2^32 (0xFFFF_FFFF wraps to 0).
  - EN=0: prescale counter and COUNT hold.
- Collisions:
  - Bus write to COUNT in the same cycle as a tick: the bus write wins, per written byte; unwritten bytes take the incremented value.
  - MATCH set and W1C in the same cycle: set wins.
  - Write to PRESCALE: also resets the prescale counter to 0.
- timer_irq = MATCH & IRQEN, driven from flops with no further register stage.
- Reset asserted mid-transaction or mid-count: everything returns to reset values immediately (asynchronous); no pending access completes.

Optional Feature:
- Macro: NANORV32_PERIPH_TIMER_PRESCALER_EN.
- Defined: PRESCALE register and prescale counter are implemented as described above.
- Undefined: no prescale counter; tick = EN every cycle; PRESCALE reads 0 and writes to it are ignored.

Decomposition:
- Shared package nanorv32_periph_pkg holds:
  - register offset constants: TIMER_CTRL_OFF, TIMER_PRESCALE_OFF, TIMER_COUNT_OFF, TIMER_COMPARE_OFF, TIMER_STATUS_OFF;
  - CTRL bit indices;
  - FSM state encoding.
- One sub-module: nanorv32_periph_slave_if. It contains the handshake FSM and wait-state counter, and outputs the wr_en/rd_en/offset strobes.
- The timer core and register file stay in the top module.

Test Plan:
- WAIT_STATES=0. Write 0x0000_0010 to COMPARE (bytesel 0xF), then read it → ready_nxt high in the en cycle; ready_r next cycle; dout=0x10.
- WAIT_STATES=3. Read CTRL after reset → ready_nxt asserts exactly 3 cycles after en rises; dout=0. Drop en after 1 cycle → no ready_nxt; FSM back in IDLE.
- COMPARE=5, PRESCALE=0, CTRL=0x7 → MATCH and timer_irq set on the 6th tick; COUNT reads 0 afterwards. Write STATUS=0x1 → irq low.
- AUTORELOAD=0, COUNT=0xFFFF_FFFE, COMPARE=0x10, EN → COUNT goes 0xFFFF_FFFF then 0x0; no MATCH.
- PRESCALE=3 (macro defined), EN=1 → COUNT increments once per 4 cycles. Macro undefined → once per cycle, and PRESCALE reads 0.
- Byte write bytesel=0x2, din=0x0000_AB00 to COMPARE=0x1122_3344 → COMPARE=0x1122_AB44. W1C and match in the same cycle → MATCH stays 1.
